// File: rtl/div_sched.sv
// rtl/div_sched.sv - two-requester round-robin scheduler for a shared multi-cycle divider
// Optional zero-divisor flag outputs enabled by DIV_SCHED_ZERO_FLAG_EN.
module div_sched #(
    parameter int DATA_W     = 32,
    parameter int GAP_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic                req0_signed,
    input  logic [DATA_W-1:0]   req0_dividend,
    input  logic [DATA_W-1:0]   req0_divisor,
    input  logic                req0_cancel,
    output logic                req0_stall,
    output logic                req0_done,
    output logic [2*DATA_W-1:0] req0_res,
    input  logic                req1_valid,
    input  logic                req1_signed,
    input  logic [DATA_W-1:0]   req1_dividend,
    input  logic [DATA_W-1:0]   req1_divisor,
    input  logic                req1_cancel,
    output logic                req1_stall,
    output logic                req1_done,
    output logic [2*DATA_W-1:0] req1_res,
`ifdef DIV_SCHED_ZERO_FLAG_EN
    output logic                req0_div0,
    output logic                req1_div0,
`endif
    output logic                div_start_out,
    output logic                div_cancel_out,
    output logic                div_signed_out,
    output logic [DATA_W-1:0]   div_dived_out,
    output logic [DATA_W-1:0]   div_div_out,
    input  logic [2*DATA_W-1:0] div_res_in,
    input  logic                div_ready_in
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic [1:0]          r_state;
    logic                r_rr;
    logic                r_owner;
    logic [GW-1:0]       r_gap;
    logic                r_done0;
    logic                r_done1;
    logic [2*DATA_W-1:0] r_res0;
    logic [2*DATA_W-1:0] r_res1;
    logic                r_start;
    logic                r_cancel;
    logic                r_signed;
    logic [DATA_W-1:0]   r_dived;
    logic [DATA_W-1:0]   r_div;
`ifdef DIV_SCHED_ZERO_FLAG_EN
    logic                r_zero;
    logic                r_div0_0;
    logic                r_div0_1;
`endif

    logic              w_cand0;
    logic              w_cand1;
    logic              w_grant_idx;
    logic              w_owner_cancel;
    logic              w_sel_signed;
    logic [DATA_W-1:0] w_sel_dived;
    logic [DATA_W-1:0] w_sel_div;

    assign w_cand0 = req0_valid & ~req0_cancel;
    assign w_cand1 = req1_valid & ~req1_cancel;
    // With both candidates the pointer decides; otherwise the lone candidate wins.
    assign w_grant_idx    = (w_cand0 & w_cand1) ? r_rr : w_cand1;
    assign w_owner_cancel = r_owner ? req1_cancel : req0_cancel;
    assign w_sel_signed   = w_grant_idx ? req1_signed   : req0_signed;
    assign w_sel_dived    = w_grant_idx ? req1_dividend : req0_dividend;
    assign w_sel_div      = w_grant_idx ? req1_divisor  : req0_divisor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr     <= 1'b0;
            r_owner  <= 1'b0;
            r_gap    <= '0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_res0   <= '0;
            r_res1   <= '0;
            r_start  <= 1'b0;
            r_cancel <= 1'b0;
            r_signed <= 1'b0;
            r_dived  <= '0;
            r_div    <= '0;
`ifdef DIV_SCHED_ZERO_FLAG_EN
            r_zero   <= 1'b0;
            r_div0_0 <= 1'b0;
            r_div0_1 <= 1'b0;
`endif
        end else begin
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_cancel <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cand0 | w_cand1) begin
                        r_owner  <= w_grant_idx;
                        r_rr     <= ~w_grant_idx;
                        r_signed <= w_sel_signed;
                        r_dived  <= w_sel_dived;
                        r_div    <= w_sel_div;
`ifdef DIV_SCHED_ZERO_FLAG_EN
                        r_zero   <= (w_sel_div == '0);
`endif
                        r_start  <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Cancel takes priority even when the result lands in the same cycle.
                    if (w_owner_cancel) begin
                        r_start  <= 1'b0;
                        r_cancel <= 1'b1;
                        r_gap    <= '0;
                        r_state  <= S_GAP;
                    end else if (div_ready_in) begin
                        r_start <= 1'b0;
                        r_gap   <= '0;
                        r_state <= S_GAP;
                        if (r_owner) begin
                            r_res1   <= div_res_in;
                            r_done1  <= 1'b1;
`ifdef DIV_SCHED_ZERO_FLAG_EN
                            r_div0_1 <= r_zero;
`endif
                        end else begin
                            r_res0   <= div_res_in;
                            r_done0  <= 1'b1;
`ifdef DIV_SCHED_ZERO_FLAG_EN
                            r_div0_0 <= r_zero;
`endif
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_gap   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req0_done      = r_done0;
    assign req1_done      = r_done1;
    assign req0_res       = r_res0;
    assign req1_res       = r_res1;
    assign req0_stall     = req0_valid & ~req0_cancel & ~r_done0;
    assign req1_stall     = req1_valid & ~req1_cancel & ~r_done1;
    assign div_start_out  = r_start;
    assign div_cancel_out = r_cancel;
    assign div_signed_out = r_signed;
    assign div_dived_out  = r_dived;
    assign div_div_out    = r_div;
`ifdef DIV_SCHED_ZERO_FLAG_EN
    assign req0_div0      = r_div0_0;
    assign req1_div0      = r_div0_1;
`endif

endmodule

// File: tb/tb_div_sched.sv
// tb/tb_div_sched.sv - directed self-checking bench for div_sched with a behavioural div unit
module tb_div_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 0, req0_signed = 0, req0_cancel = 0;
    logic [31:0] req0_dividend = 0, req0_divisor = 0;
    logic        req1_valid = 0, req1_signed = 0, req1_cancel = 0;
    logic [31:0] req1_dividend = 0, req1_divisor = 0;
    logic        req0_stall, req0_done, req1_stall, req1_done;
    logic [63:0] req0_res, req1_res;
`ifdef DIV_SCHED_ZERO_FLAG_EN
    logic        req0_div0, req1_div0;
`endif
    logic        div_start_out, div_cancel_out, div_signed_out;
    logic [31:0] div_dived_out, div_div_out;
    logic [63:0] div_res_in;
    logic        div_ready_in;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_sched #(.DATA_W(32), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_signed(req0_signed), .req0_dividend(req0_dividend),
        .req0_divisor(req0_divisor), .req0_cancel(req0_cancel), .req0_stall(req0_stall),
        .req0_done(req0_done), .req0_res(req0_res),
        .req1_valid(req1_valid), .req1_signed(req1_signed), .req1_dividend(req1_dividend),
        .req1_divisor(req1_divisor), .req1_cancel(req1_cancel), .req1_stall(req1_stall),
        .req1_done(req1_done), .req1_res(req1_res),
`ifdef DIV_SCHED_ZERO_FLAG_EN
        .req0_div0(req0_div0), .req1_div0(req1_div0),
`endif
        .div_start_out(div_start_out), .div_cancel_out(div_cancel_out),
        .div_signed_out(div_signed_out), .div_dived_out(div_dived_out),
        .div_div_out(div_div_out), .div_res_in(div_res_in), .div_ready_in(div_ready_in)
    );

    // Div unit: ready 36 cycles after start (4 for a zero divisor), reset by start low or cancel.
    int unsigned m_cnt;
    logic [31:0] m_q, m_r;
    always @(posedge clk or posedge rst) begin
        if (rst) m_cnt <= 0;
        else if (!div_start_out || div_cancel_out) m_cnt <= 0;
        else m_cnt <= m_cnt + 1;
    end
    always_comb begin
        m_q = '0;
        m_r = '0;
        if (div_div_out != 32'd0) begin
            if (div_signed_out) begin
                m_q = $signed(div_dived_out) / $signed(div_div_out);
                m_r = $signed(div_dived_out) % $signed(div_div_out);
            end else begin
                m_q = div_dived_out / div_div_out;
                m_r = div_dived_out % div_div_out;
            end
        end
    end
    assign div_res_in   = {m_r, m_q};
    assign div_ready_in = div_start_out && (m_cnt == ((div_div_out == 32'd0) ? 32'd3 : 32'd35));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input int exp_wait, input logic [31:0] exp_dived, input string tag);
        int k;
        k = 0;
        while (!div_start_out && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_grant_wait"}, 64'(k), 64'(exp_wait));
        chk({tag, "_dividend"}, {32'd0, div_dived_out}, {32'd0, exp_dived});
    endtask

    task automatic wait_done(input int which, input int exp_cyc, input logic [63:0] exp_res,
                             input logic other_busy, input string tag);
        int   cyc;
        logic own_ok, other_ok, d;
        cyc = 0; own_ok = 1'b1; other_ok = 1'b1;
        d = which ? req1_done : req0_done;
        while (!d && cyc < 200) begin
            if (!(which ? req1_stall : req0_stall)) own_ok = 1'b0;
            if (other_busy && !(which ? req0_stall : req1_stall)) other_ok = 1'b0;
            tick();
            cyc++;
            d = which ? req1_done : req0_done;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_res"}, which ? req1_res : req0_res, exp_res);
        chk({tag, "_stall_before_done"}, {63'd0, own_ok}, 64'd1);
        chk({tag, "_stall_at_done"}, {63'd0, which ? req1_stall : req0_stall}, 64'd0);
        if (other_busy) begin
            other_ok = other_ok & (which ? req0_stall : req1_stall);
            chk({tag, "_other_stall"}, {63'd0, other_ok}, 64'd1);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_start", {63'd0, div_start_out}, 64'd0);
        chk("rst_cancel", {63'd0, div_cancel_out}, 64'd0);
        chk("rst_dived", {32'd0, div_dived_out}, 64'd0);
        chk("rst_done", {62'd0, req0_done, req1_done}, 64'd0);
        chk("rst_res0", req0_res, 64'd0);
        rst = 1'b0;

        // Unsigned 100/7 on requester 0
        req0_valid = 1; req0_dividend = 100; req0_divisor = 7;
        tick();
        chk("u_start", {63'd0, div_start_out}, 64'd1);
        chk("u_divisor", {32'd0, div_div_out}, 64'd7);
        chk("u_signed", {63'd0, div_signed_out}, 64'd0);
        wait_done(0, 36, {32'h2, 32'hE}, 1'b0, "u100_7");
`ifdef DIV_SCHED_ZERO_FLAG_EN
        chk("u_div0", {63'd0, req0_div0}, 64'd0);
`endif
        req0_valid = 0;

        // Signed -7/2 on requester 1
        req1_valid = 1; req1_signed = 1; req1_dividend = 32'hFFFFFFF9; req1_divisor = 2;
        wait_grant(3, 32'hFFFFFFF9, "s");
        chk("s_signed", {63'd0, div_signed_out}, 64'd1);
        wait_done(1, 36, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, "s_m7_2");
        req1_signed = 0;

        // Both request together: round-robin alternation 0,1,0,1
        req0_valid = 1; req0_dividend = 20; req0_divisor = 3;
        req1_dividend = 9; req1_divisor = 4;
        wait_grant(3, 20, "rr_a");
        wait_done(0, 36, {32'h2, 32'h6}, 1'b1, "rr_a");
        req0_dividend = 50; req0_divisor = 5;
        wait_grant(3, 9, "rr_b");
        wait_done(1, 36, {32'h1, 32'h2}, 1'b1, "rr_b");
        req1_dividend = 13; req1_divisor = 4;
        wait_grant(3, 50, "rr_c");
        wait_done(0, 36, {32'h0, 32'hA}, 1'b1, "rr_c");
        req0_valid = 0;
        wait_grant(3, 13, "rr_d");
        wait_done(1, 36, {32'h1, 32'h3}, 1'b0, "rr_d");

        // Owner cancel with requester 1 pending
        req0_valid = 1; req0_dividend = 100; req0_divisor = 7;
        req1_dividend = 40; req1_divisor = 6;
        wait_grant(3, 100, "cx");
        for (int i = 0; i < 10; i++) tick();
        req0_cancel = 1;
        tick();
        chk("cx_cancel_pulse", {63'd0, div_cancel_out}, 64'd1);
        chk("cx_start_low", {63'd0, div_start_out}, 64'd0);
        chk("cx_no_done", {63'd0, req0_done}, 64'd0);
        req0_cancel = 0; req0_valid = 0;
        tick();
        chk("cx_cancel_one_cycle", {63'd0, div_cancel_out}, 64'd0);
        chk("cx_no_done2", {63'd0, req0_done}, 64'd0);
        wait_grant(2, 40, "cx_next");
        tick();
        tick();
        req0_cancel = 1;
        tick();
        chk("nonowner_cancel", {63'd0, div_cancel_out}, 64'd0);
        chk("nonowner_start", {63'd0, div_start_out}, 64'd1);
        req0_cancel = 0;
        wait_done(1, 33, {32'h4, 32'h6}, 1'b0, "cx_r1");
        req1_valid = 0;

        // Zero divisor
        req0_valid = 1; req0_dividend = 5; req0_divisor = 0;
        wait_grant(3, 5, "z");
        wait_done(0, 4, 64'd0, 1'b0, "z5_0");
`ifdef DIV_SCHED_ZERO_FLAG_EN
        chk("z_div0", {63'd0, req0_div0}, 64'd1);
`endif
        req0_valid = 0;

        // Reset during RUN, then a fresh operation
        req0_valid = 1; req0_dividend = 100; req0_divisor = 7;
        wait_grant(3, 100, "mr");
        for (int i = 0; i < 5; i++) tick();
        rst = 1;
        #1;
        chk("mr_start", {63'd0, div_start_out}, 64'd0);
        chk("mr_dived", {32'd0, div_dived_out}, 64'd0);
        chk("mr_res0", req0_res, 64'd0);
        chk("mr_res1", req1_res, 64'd0);
        @(negedge clk);
        rst = 0;
        tick();
        chk("mr_regrant", {63'd0, div_start_out}, 64'd1);
        wait_done(0, 36, {32'h2, 32'hE}, 1'b0, "mr_100_7");
        req0_valid = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Shared-divider scheduler. Arbitrates two requesters (requester 0 = EX-stage DIV/DIVU, requester 1 = auxiliary/coprocessor port) onto the single multi-cycle div unit.
- Drives the div unit's start/cancel handshake and returns the 64-bit {remainder, quotient} result to the owning requester.
- Provides per-requester stall and cancel (flush) handling.

Parameters:
- DATA_W, 32, operand width; result width is 2*DATA_W.
- GAP_CYCLES, 2, idle cycles with start low after a completion or cancel, so the div unit returns to its free state.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- reqN_valid  input  1  request pending (N = 0,1); held until reqN_done or reqN_cancel
- reqN_signed  input  1  signed (DIV) vs unsigned (DIVU)
- reqN_dividend  input  DATA_W  dividend
- reqN_divisor  input  DATA_W  divisor
- reqN_cancel  input  1  flush of requester N's pending operation
- reqN_stall  output  1  requester must hold its pipeline stage
- reqN_done  output  1  one-cycle result-valid pulse
- reqN_res  output  2*DATA_W  {remainder, quotient}; held until that requester's next done
- div_start_out  output  1  to div unit start
- div_cancel_out  output  1  to div unit cancel
- div_signed_out  output  1  latched signed flag
- div_dived_out  output  DATA_W  latched dividend
- div_div_out  output  DATA_W  latched divisor
- div_res_in  input  2*DATA_W  div unit result
- div_ready_in  input  1  div unit ready

Behaviour:
- Reset (async, rst=1): state IDLE, rr pointer = 0, owner = 0.
- Reset values: all div_* outputs 0, reqN_done 0, reqN_res 0, gap counter 0.
- Reset mid-operation drops div_start_out immediately. The div unit is reset by the same system reset.
- States:
  - IDLE: candidates are reqN_valid & !reqN_cancel.
    - One candidate: grant it.
    - Both: grant the one the rr pointer selects (pointer = preferred index).
    - On grant (registered): latch the requester's operands and signed flag into div_*_out, set owner, set div_start_out=1, set pointer = the other requester, go to RUN.
  - RUN: div_start_out held 1.
    - div_ready_in=1 and owner not cancelling: capture div_res_in into res[owner], pulse done[owner] the next cycle, drop start, go to GAP.
    - Owner cancel (at any cycle in RUN, including the cycle ready arrives; cancel wins): drop start, pulse div_cancel_out for 1 cycle, no done, go to GAP.
  - GAP: start and cancel low for GAP_CYCLES cycles, then IDLE. A new grant is only possible from IDLE.
- reqN_stall is combinational: reqN_valid & !reqN_cancel & !reqN_done. The non-owner stalls for the entire busy period.
- Cancel from a requester that does not own the unit has no effect on the divider.
- Result width and format are passed through unchanged. Divisor 0 yields the div unit's result (all zeros). Sign correction is the div unit's job.
- Latency, grant edge to done pulse:
  - 36 cycles nominal.
  - 4 cycles for a zero divisor.
  - Back-to-back: next grant occurs GAP_CYCLES+1 cycles after the done pulse.
- Simultaneous valid from both requesters, same cycle: fairness via rr. With continuous requests from both, grants alternate 0,1,0,1.
- Operands changing after grant are ignored (latched).

Optional Feature:
- Macro: DIV_SCHED_ZERO_FLAG_EN.
- Defined:
  - Extra outputs reqN_div0 (1 bit each), valid with reqN_done.
  - Set when the latched divisor was zero, computed at grant from the latched operands.
  - Reset value 0.
- Not defined: ports absent; zero-divisor result is indistinguishable from a genuine all-zero result.

Test Plan:
- Unsigned req0: 100/7 -> req0_done after 36 cycles, req0_res = {32'h2, 32'hE}. req0_stall high until the done cycle.
- Signed req1: -7/2 (32'hFFFFFFF9 / 32'h2) -> req1_res = {32'hFFFFFFFF, 32'hFFFFFFFD}.
- Both valid in the same cycle after reset: req0 granted first (pointer 0), then req1 granted 3 cycles after req0_done.
  - req1_stall stays high throughout.
  - Continued requests alternate grants.
- req0 cancel 10 cycles after grant -> div_cancel_out one-cycle pulse, no req0_done, start low 2 cycles, then a pending req1 is granted.
- Zero divisor 5/0 -> done after 4 cycles, res = 0. With DIV_SCHED_ZERO_FLAG_EN, req0_div0 = 1.
- Assert rst during RUN -> all outputs 0 asynchronously. After release, a fresh 100/7 completes correctly.
